// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: FSM states, grant owner and byte-lane word.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  // Byte 0 is the most significant lane (bits 31:24).
  typedef logic [0:3][7:0] word_bytes_t;

  localparam int unsigned CNT_W = 4;

  function automatic logic [31:0] bytes_to_word(input word_bytes_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic word_bytes_t word_to_bytes(input logic [31:0] w);
    word_bytes_t b;
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    return b;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter timing the memory access: load, decrement, and a zero flag.
module mem_lat_counter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single fixed-latency memory.
// Define MEM_ARB_RR_EN to alternate contested grants; otherwise the data side wins.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] address_output,
  output word_bytes_t mem_data_in,
  input  word_bytes_t mem_data_out,
  output logic        write_en_out,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(LATENCY - 1);

  arb_state_t  state_reg, state_next;
  owner_t      owner_reg;
  owner_t      grant_owner;
  logic        we_reg;
  logic [31:0] addr_reg;
  word_bytes_t wdata_reg;
  logic [31:0] i_rdata_reg;
  logic [31:0] d_rdata_reg;

  logic grant;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic capture;

`ifdef MEM_ARB_RR_EN
  // 0 favours the instruction side on the next contested grant.
  logic rr_ptr_reg;
  logic contested;

  assign contested = i_req && d_req;

  always_comb begin
    grant_owner = d_req ? OWNER_D : OWNER_I;
    if (contested) begin
      grant_owner = rr_ptr_reg ? OWNER_D : OWNER_I;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg <= 1'b0;
    end else if (grant && contested) begin
      rr_ptr_reg <= ~rr_ptr_reg;
    end
  end
`else
  always_comb begin
    grant_owner = d_req ? OWNER_D : OWNER_I;
  end
`endif

  mem_lat_counter u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (LOAD_VALUE),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          grant      = 1'b1;
          cnt_load   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Transaction context is latched once at grant and held until the next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_reg <= OWNER_I;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (grant) begin
      owner_reg <= grant_owner;
      if (grant_owner == OWNER_D) begin
        we_reg   <= d_we;
        addr_reg <= d_addr;
        if (d_we) begin
          wdata_reg <= word_to_bytes(d_wdata);
        end
      end else begin
        we_reg   <= 1'b0;
        addr_reg <= i_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else if (capture) begin
      if (owner_reg == OWNER_I) begin
        i_rdata_reg <= bytes_to_word(mem_data_out);
      end else if (!we_reg) begin
        d_rdata_reg <= bytes_to_word(mem_data_out);
      end
    end
  end

  assign address_output = addr_reg;
  assign mem_data_in    = wdata_reg;
  assign write_en_out   = (state_reg == ACCESS) && (owner_reg == OWNER_D) && we_reg;
  assign busy           = (state_reg != IDLE);
  assign i_ack          = (state_reg == RESP) && (owner_reg == OWNER_I);
  assign d_ack          = (state_reg == RESP) && (owner_reg == OWNER_D);
  assign i_rdata        = i_rdata_reg;
  assign d_rdata        = d_rdata_reg;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, SHALL give the memory access time in cycles; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_req  input  1  SHALL be the instruction-side read request, held until i_ack.
REQ-005 i_addr  input  32  SHALL be the instruction-side word address.
REQ-006 i_rdata  output  32  SHALL be the instruction-side read data.
REQ-007 i_ack  output  1  SHALL be a one-cycle completion pulse for the instruction side.
REQ-008 d_req  input  1  SHALL be the data-side request, held until d_ack.
REQ-009 d_we  input  1  SHALL select write (1) or read (0) for the data side.
REQ-010 d_addr  input  32  SHALL be the data-side word address.
REQ-011 d_wdata  input  32  SHALL be the data-side write data.
REQ-012 d_rdata  output  32  SHALL be the data-side read data.
REQ-013 d_ack  output  1  SHALL be a one-cycle completion pulse for the data side.
REQ-014 address_output  output  32  SHALL be the address driven to memory.
REQ-015 mem_data_in  output  4x8  SHALL be the write bytes to memory; byte 0 = bits 31:24.
REQ-016 mem_data_out  input  4x8  SHALL be the read bytes from memory; byte 0 = bits 31:24.
REQ-017 write_en_out  output  1  SHALL be the memory write strobe.
REQ-018 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-019 FSM SHALL have states IDLE, ACCESS, RESP.
REQ-020 IDLE with any request: grant per policy, latch address, we, wdata and grant owner; go ACCESS; load counter with LATENCY-1.
REQ-021 ACCESS: address_output, mem_data_in, write_en_out SHALL be driven from latched values, stable every cycle; counter decrements; at counter 0 capture read bytes and go RESP.
REQ-022 RESP: pulse ack of granted side only; return to IDLE; no new grant in RESP.
REQ-023 Request sampled in IDLE at cycle N SHALL be acked at cycle N+LATENCY+1; back-to-back transactions separated by one IDLE cycle.
REQ-024 Read data SHALL be {mem_data_out[0],[1],[2],[3]}, valid in ack cycle, held in the side's rdata register until that side's next read completes.
REQ-025 write_en_out SHALL be 1 only in ACCESS of a data-side write; 0 otherwise; writes leave d_rdata unchanged.
REQ-026 Instruction side SHALL always be read; i_req and d_req never both acked in one cycle.
REQ-027 Simultaneous i_req and d_req without RR: data side SHALL win.
REQ-028 Request deassertion during ACCESS SHALL not abort; ack still issued.
REQ-029 Outside ACCESS, address_output, mem_data_in SHALL hold last values; write_en_out 0.

Reset
REQ-030 Reset low SHALL immediately force IDLE, acks 0, write_en_out 0, busy 0, address_output 0, mem_data_in 0, rdata 0, counter 0, RR pointer to instruction-favoured; in-flight transaction aborted without ack.
REQ-031 First grant SHALL occur no earlier than the first rising edge after reset release.

Configuration
REQ-032 With MEM_ARB_RR_EN defined, simultaneous requests SHALL alternate via a one-bit pointer toggled on each contested grant, instruction side first after reset.
REQ-033 Without MEM_ARB_RR_EN, fixed data-side priority per REQ-027; no pointer flop exists.

Structure
REQ-034 Package mem_pkg SHALL hold the FSM state enum, the grant-owner enum, and byte-array typedef word_bytes_t (4x8).
REQ-035 One sub-module mem_lat_counter (load, decrement, zero flag) SHALL implement the latency count.

Verification
REQ-036 Read: d_req=1, d_we=0, d_addr=0x100, mem_data_out={0xDE,0xAD,0xBE,0xEF} -> d_ack at N+5, d_rdata=0xDEADBEEF, write_en_out 0 throughout.
REQ-037 Write: d_we=1, d_addr=0x200, d_wdata=0x12345678 -> 4 cycles write_en_out=1, address_output=0x200, mem_data_in={0x12,0x34,0x56,0x78}, d_ack at N+5.
REQ-038 Contention: i_req and d_req held together for 4 transactions -> without macro D,D,D,D; with MEM_ARB_RR_EN I,D,I,D.
REQ-039 Reset mid-ACCESS: reset low in 2nd ACCESS cycle -> write_en_out 0 and busy 0 same cycle, no ack, next request completes normally.
REQ-040 LATENCY=1: i_req, i_addr=0x4 -> i_ack at N+2, busy high exactly 2 cycles.
